// File: rtl/mem_access.sv
// MEM stage of the ARC MIPS pipeline: data-memory req/ack access with timeout,
// branch resolution, and the MEM/WB pipeline register.
module mem_access #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_con_mem_branch,
    input  logic        i_con_mem_memread,
    input  logic        i_con_mem_memwrite,
    input  logic        i_con_wb_memtoreg,
    input  logic        i_con_wb_regwrite,
    input  logic [31:0] i_data_AddRst,
    input  logic        i_con_Zero,
    input  logic [31:0] i_data_ALU_Rst,
    input  logic [31:0] i_data_rt,
    input  logic [4:0]  i_addr_MuxRst,
    output logic        o_con_PCSrc,
    output logic [31:0] o_addr_PCBranch,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_err_align,
    output logic        o_err_timeout,
    output logic        o_con_wb_regwrite,
    output logic        o_con_wb_memtoreg,
    output logic [31:0] o_data_ReadData,
    output logic [31:0] o_data_ALU_Rst,
    output logic [4:0]  o_addr_MuxRst
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          access, misaligned, timeout_hit;

    assign access      = i_con_mem_memread | i_con_mem_memwrite;
    assign misaligned  = access & (i_data_ALU_Rst[1:0] != 2'b00);
    assign timeout_hit = (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_stall   = 1'b0;
        unique case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    o_stall   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                o_stall = !i_dmem_ack && !timeout_hit;
                if (i_dmem_ack || timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gating with stall makes a branch resolve only in its last MEM cycle.
    assign o_con_PCSrc     = i_con_mem_branch & i_con_Zero & !o_stall;
    assign o_addr_PCBranch = i_data_AddRst;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt               <= '0;
            o_dmem_req        <= 1'b0;
            o_dmem_we         <= 1'b0;
            o_dmem_addr       <= '0;
            o_dmem_wdata      <= '0;
            o_err_align       <= 1'b0;
            o_err_timeout     <= 1'b0;
            o_con_wb_regwrite <= 1'b0;
            o_con_wb_memtoreg <= 1'b0;
            o_data_ReadData   <= '0;
            o_data_ALU_Rst    <= '0;
            o_addr_MuxRst     <= '0;
        end else begin
            o_err_align   <= 1'b0;
            o_err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!access) begin
                        o_con_wb_regwrite <= i_con_wb_regwrite;
                        o_con_wb_memtoreg <= i_con_wb_memtoreg;
                        o_data_ReadData   <= '0;
                        o_data_ALU_Rst    <= i_data_ALU_Rst;
                        o_addr_MuxRst     <= i_addr_MuxRst;
                    end else begin
                        o_con_wb_regwrite <= 1'b0;
                        o_con_wb_memtoreg <= 1'b0;
                        o_data_ReadData   <= '0;
                        o_data_ALU_Rst    <= '0;
                        o_addr_MuxRst     <= '0;
                        if (misaligned) begin
                            o_err_align <= 1'b1;
                        end else begin
                            o_dmem_req   <= 1'b1;
                            o_dmem_we    <= i_con_mem_memwrite;
                            o_dmem_addr  <= i_data_ALU_Rst;
                            o_dmem_wdata <= i_data_rt;
                            cnt          <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (i_dmem_ack) begin
                        o_dmem_req        <= 1'b0;
                        o_con_wb_regwrite <= i_con_wb_regwrite;
                        o_con_wb_memtoreg <= i_con_wb_memtoreg;
                        o_data_ReadData   <= (i_con_mem_memread && !i_con_mem_memwrite)
                                             ? i_dmem_rdata : '0;
                        o_data_ALU_Rst    <= i_data_ALU_Rst;
                        o_addr_MuxRst     <= i_addr_MuxRst;
                    end else if (timeout_hit) begin
                        o_dmem_req    <= 1'b0;
                        o_err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: o_dmem_req <= 1'b0;
            endcase
        end
    end

endmodule
